// File: rtl/audio_peak_meter.sv
// Stereo peak meter: 2-stage magnitude/peak pipeline, per-channel hold/decay FSM, LED bars.
// Define AUDIO_PEAK_METER_CLIP_EN to build in the sticky full-scale clip flags.
module audio_peak_meter #(
   parameter int HOLD_SAMPLES  = 4800,
   parameter int DECAY_SAMPLES = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [23:0] audio_l,
   input  logic [23:0] audio_r,
   input  logic        clip_clr,
   output logic [7:0]  peak_l,
   output logic [7:0]  peak_r,
   output logic [7:0]  bar_l,
   output logic [7:0]  bar_r,
   output logic        clip_l,
   output logic        clip_r
);

   localparam int          DATA_W     = 24;
   localparam int          MAG_W      = DATA_W - 1;
   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_SAMPLES - 1);
   localparam logic [15:0] DECAY_LAST = 16'(DECAY_SAMPLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

   function automatic logic [MAG_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W-1:0] neg;
      neg = -x;
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         sat_abs = '1;
      else if (x[DATA_W-1])
         sat_abs = neg[MAG_W-1:0];
      else
         sat_abs = x[MAG_W-1:0];
   endfunction

   function automatic logic [7:0] to_bar(input logic [7:0] level);
      for (int i = 0; i < 8; i++)
         to_bar[i] = (level > 8'(32 * i));
   endfunction

   logic signed [DATA_W-1:0] audio_l_s, audio_r_s;
   logic [MAG_W-1:0]         mag_p1 [2];
   logic                     vld_p1;
   logic [7:0]               peak_p2 [2];
   state_t                   state_p2 [2];
   logic [15:0]              hold_cnt [2];
   logic [15:0]              decay_cnt [2];

   assign audio_l_s = audio_l;
   assign audio_r_s = audio_r;

   // Stage 1: saturated magnitude capture
   always_ff @(posedge clk) begin
      if (sample_valid) begin
         mag_p1[0] <= sat_abs(audio_l_s);
         mag_p1[1] <= sat_abs(audio_r_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= sample_valid;
   end

   // Stage 2: candidate level and hold/decay FSM per channel
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            peak_p2[c]   <= 8'd0;
            state_p2[c]  <= IDLE;
            hold_cnt[c]  <= 16'd0;
            decay_cnt[c] <= 16'd0;
         end
      end else if (vld_p1) begin
         for (int c = 0; c < 2; c++) begin
            // A new loudest sample always wins over a pending decay step
            if ((mag_p1[c][22:15] >= peak_p2[c]) &&
                !(state_p2[c] == IDLE && mag_p1[c][22:15] == 8'd0)) begin
               peak_p2[c]   <= mag_p1[c][22:15];
               hold_cnt[c]  <= 16'd0;
               decay_cnt[c] <= 16'd0;
               state_p2[c]  <= HOLD;
            end else begin
               case (state_p2[c])
                  HOLD: begin
                     if (hold_cnt[c] == HOLD_LAST) begin
                        decay_cnt[c] <= 16'd0;
                        state_p2[c]  <= DECAY;
                     end else begin
                        hold_cnt[c] <= hold_cnt[c] + 16'd1;
                     end
                  end
                  DECAY: begin
                     if (decay_cnt[c] == DECAY_LAST) begin
                        decay_cnt[c] <= 16'd0;
                        if (peak_p2[c] <= 8'd1) begin
                           peak_p2[c]  <= 8'd0;
                           state_p2[c] <= IDLE;
                        end else begin
                           peak_p2[c] <= peak_p2[c] - 8'd1;
                        end
                     end else begin
                        decay_cnt[c] <= decay_cnt[c] + 16'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign peak_l = peak_p2[0];
   assign peak_r = peak_p2[1];
   assign bar_l  = to_bar(peak_p2[0]);
   assign bar_r  = to_bar(peak_p2[1]);

`ifdef AUDIO_PEAK_METER_CLIP_EN
   function automatic logic is_full_scale(input logic signed [DATA_W-1:0] x);
      is_full_scale = (x == {1'b0, {(DATA_W-1){1'b1}}}) || (x == {1'b1, {(DATA_W-1){1'b0}}});
   endfunction

   logic [1:0] fs_p1;
   logic [1:0] clip_p2;
   logic       unused_bits;

   always_ff @(posedge clk) begin
      if (sample_valid)
         fs_p1 <= {is_full_scale(audio_r_s), is_full_scale(audio_l_s)};
   end

   // Set has priority over a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst)
         clip_p2 <= 2'b00;
      else
         clip_p2 <= (clip_clr ? 2'b00 : clip_p2) | (vld_p1 ? fs_p1 : 2'b00);
   end

   assign clip_l      = clip_p2[0];
   assign clip_r      = clip_p2[1];
   assign unused_bits = ^{mag_p1[0][14:0], mag_p1[1][14:0]};
`else
   logic unused_bits;

   assign clip_l      = 1'b0;
   assign clip_r      = 1'b0;
   assign unused_bits = ^{mag_p1[0][14:0], mag_p1[1][14:0], clip_clr};
`endif

endmodule

// File: tb/tb_audio_peak_meter.sv
// Directed bench for audio_peak_meter with HOLD_SAMPLES=4, DECAY_SAMPLES=2.
module tb_audio_peak_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_valid = 1'b0;
   logic [23:0] audio_l = 24'd0;
   logic [23:0] audio_r = 24'd0;
   logic        clip_clr = 1'b0;
   logic [7:0]  peak_l, peak_r, bar_l, bar_r;
   logic        clip_l, clip_r;

   int errors = 0;
   int checks = 0;

`ifdef AUDIO_PEAK_METER_CLIP_EN
   localparam logic [7:0] CLIP_EXP = 8'd1;
`else
   localparam logic [7:0] CLIP_EXP = 8'd0;
`endif

   audio_peak_meter #(
      .HOLD_SAMPLES (4),
      .DECAY_SAMPLES(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(sample_valid),
      .audio_l     (audio_l),
      .audio_r     (audio_r),
      .clip_clr    (clip_clr),
      .peak_l      (peak_l),
      .peak_r      (peak_r),
      .bar_l       (bar_l),
      .bar_r       (bar_r),
      .clip_l      (clip_l),
      .clip_r      (clip_r)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      sample_valid = 1'b0;
      clip_clr = 1'b0;
      audio_l = 24'd0;
      audio_r = 24'd0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic sample(input logic [23:0] l, input logic [23:0] r);
      sample_valid = 1'b1;
      audio_l = l;
      audio_r = r;
      tick;
      sample_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] dec_exp [10];
      logic [7:0] reload_exp [6];
      dec_exp    = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
      reload_exp = '{8'd12, 8'd12, 8'd12, 8'd12, 8'd12, 8'd11};

      // Reset state
      tick;
      tick;
      chk("rst_peak_l", peak_l, 8'h00);
      chk("rst_peak_r", peak_r, 8'h00);
      chk("rst_bar_l", bar_l, 8'h00);
      chk("rst_bar_r", bar_r, 8'h00);
      chk("rst_clip_l", {7'd0, clip_l}, 8'h00);
      chk("rst_clip_r", {7'd0, clip_r}, 8'h00);

      // First sample right after reset release, two-cycle latency
      rst = 1'b0;
      sample(24'h400000, 24'h000000);
      chk("lat_early_peak_l", peak_l, 8'h00);
      tick;
      chk("half_peak_l", peak_l, 8'h80);
      chk("half_bar_l", bar_l, 8'h0F);
      chk("half_peak_r", peak_r, 8'h00);
      chk("half_bar_r", bar_r, 8'h00);

      // Hold then decay to IDLE
      do_reset;
      sample(24'h018000, 24'h000000);
      tick;
      chk("load3_peak_l", peak_l, 8'd3);
      chk("load3_bar_l", bar_l, 8'h01);
      for (int k = 0; k < 10; k++) begin
         sample(24'h000000, 24'h000000);
         tick;
         chk($sformatf("decay_k%0d", k + 1), peak_l, dec_exp[k]);
      end
      chk("decay_end_bar_l", bar_l, 8'h00);
      sample(24'h000000, 24'h000000);
      tick;
      chk("idle_stays0", peak_l, 8'd0);

      // Back-to-back strobes and ignored inputs without strobe
      do_reset;
      sample(24'h018000, 24'h000000);
      sample_valid = 1'b1;
      audio_l = 24'd0;
      audio_r = 24'd0;
      repeat (8) tick;
      sample_valid = 1'b0;
      tick;
      chk("b2b8_peak_l", peak_l, 8'd1);
      chk("b2b8_bar_l", bar_l, 8'h01);
      for (int i = 0; i < 4; i++) begin
         audio_l = (i % 2 == 0) ? 24'h7FFFFF : 24'h800000;
         audio_r = (i % 2 == 0) ? 24'h400000 : 24'h7FFFFF;
         tick;
      end
      tick;
      chk("novalid_peak_l", peak_l, 8'd1);
      chk("novalid_peak_r", peak_r, 8'd0);
      chk("novalid_clip_l", {7'd0, clip_l}, 8'd0);
      chk("novalid_clip_r", {7'd0, clip_r}, 8'd0);
      sample(24'h000000, 24'h000000);
      sample(24'h000000, 24'h000000);
      tick;
      chk("b2b10_peak_l", peak_l, 8'd0);

      // Reload during decay beats the decay step; smaller candidate does not
      do_reset;
      sample(24'h050000, 24'h000000);
      tick;
      chk("load10_peak_l", peak_l, 8'd10);
      repeat (5) sample(24'h000000, 24'h000000);
      sample(24'h060000, 24'h000000);
      tick;
      chk("reload12_peak_l", peak_l, 8'd12);
      for (int j = 0; j < 6; j++) begin
         sample(24'h000000, 24'h000000);
         tick;
         chk($sformatf("reload_j%0d", j + 1), peak_l, reload_exp[j]);
      end
      sample(24'h028000, 24'h000000);
      tick;
      chk("small_cand_a", peak_l, 8'd11);
      sample(24'h028000, 24'h000000);
      tick;
      chk("small_cand_b", peak_l, 8'd10);

      // Full-scale, negative magnitude and clip flags
      do_reset;
      sample(24'hC00000, 24'h800000);
      chk("clip_early_r", {7'd0, clip_r}, 8'd0);
      tick;
      chk("neg_peak_l", peak_l, 8'h80);
      chk("neg_bar_l", bar_l, 8'h0F);
      chk("min_peak_r", peak_r, 8'hFF);
      chk("min_bar_r", bar_r, 8'hFF);
      chk("min_clip_r", {7'd0, clip_r}, CLIP_EXP);
      chk("neg_clip_l", {7'd0, clip_l}, 8'd0);
      clip_clr = 1'b1;
      tick;
      clip_clr = 1'b0;
      chk("clr_clip_r", {7'd0, clip_r}, 8'd0);
      sample(24'h000000, 24'h7FFFFF);
      clip_clr = 1'b1;
      tick;
      clip_clr = 1'b0;
      chk("set_beats_clr_r", {7'd0, clip_r}, CLIP_EXP);
      clip_clr = 1'b1;
      tick;
      clip_clr = 1'b0;
      chk("clr2_clip_r", {7'd0, clip_r}, 8'd0);
      sample(24'h7FFFFF, 24'h7FFFFE);
      tick;
      chk("max_clip_l", {7'd0, clip_l}, CLIP_EXP);
      chk("near_fs_clip_r", {7'd0, clip_r}, 8'd0);

      // Reset mid-DECAY with a coincident strobe
      do_reset;
      sample(24'h018000, 24'h000000);
      repeat (5) sample(24'h000000, 24'h000000);
      tick;
      chk("pre_rst_peak_l", peak_l, 8'd3);
      rst = 1'b1;
      sample_valid = 1'b1;
      audio_l = 24'h7FFFFF;
      audio_r = 24'h7FFFFF;
      tick;
      rst = 1'b0;
      sample_valid = 1'b0;
      chk("midrst_peak_l", peak_l, 8'd0);
      chk("midrst_bar_l", bar_l, 8'd0);
      chk("midrst_peak_r", peak_r, 8'd0);
      chk("midrst_clip_l", {7'd0, clip_l}, 8'd0);
      tick;
      tick;
      chk("discard_peak_l", peak_l, 8'd0);
      chk("discard_peak_r", peak_r, 8'd0);
      chk("discard_clip_r", {7'd0, clip_r}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
